note_lane_engine: RTL and testbench
===================================

NOTE_LANE_ENGINE -- requirements
Module: note_lane_engine

Interface
REQ-001 Parameter LANES, default 4: number of note lanes.
REQ-002 Parameter SLOTS, default 3: note slots per lane.
REQ-003 Parameter YW, default 11: signed note-y width in bits.
REQ-004 Parameters NOTE_H=50, HIT_Y=350, HIT_H=20, SCREEN_H=480, SPEED=1: geometry in pixels and scroll step.
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 tick  in  1  one-cycle frame strobe; advances all notes.
REQ-008 spawn_valid  in  1  request to insert a note.
REQ-009 spawn_lane  in  clog2(LANES)  lane for the spawned note.
REQ-010 spawn_ready  out  1  selected lane has a free slot (combinational).
REQ-011 strum  in  1  one-cycle strum pulse.
REQ-012 buttons  in  LANES  held fret buttons, active-high.
REQ-013 query_y  in  10  scan-line y from the VGA timing generator.
REQ-014 in_note  out  LANES  bit i high when query_y lies in any valid note of lane i (combinational).
REQ-015 in_window  out  LANES  bit i high when lane i has a valid note intersecting the hit bar.
REQ-016 hit  out  1  registered one-cycle hit pulse.
REQ-017 miss  out  1  registered one-cycle miss pulse.
REQ-018 hit_count, miss_count  out  16 each  saturating event counters.

Function
REQ-019 Each slot holds valid plus signed y (top edge); a note occupies rows y..y+NOTE_H-1.
REQ-020 Spawn fires when spawn_valid and spawn_ready are both high; the lowest-index free slot of spawn_lane takes valid=1, y=-NOTE_H.
REQ-021 On tick, every valid slot adds SPEED to y; a slot whose new y >= SCREEN_H is cleared.
REQ-022 A slot cleared by tick without having been hit pulses miss the next cycle; multiple slots expiring on one tick count once per slot in miss_count, with a single miss pulse.
REQ-023 Intersection is y < HIT_Y+HIT_H and y+NOTE_H > HIT_Y, evaluated in signed YW-bit arithmetic.
REQ-024 On strum, for each lane with buttons[i]=1 and in_window[i]=1, the lowest-index intersecting slot is cleared, and each cleared note adds one to hit_count.
REQ-025 hit pulses when at least one note was cleared by the strum; miss pulses when a pressed lane had no note in the window, or when no buttons were pressed.
REQ-026 A strum with in_window all-zero is ignored: no pulse and no count change.
REQ-027 A strum coinciding with a tick is evaluated against pre-tick positions; a slot cleared by the strum is not advanced and is not counted as expired.
REQ-028 A spawn coinciding with a tick inserts at y=-NOTE_H without advancing that cycle.
REQ-029 A spawn targeting a slot freed in the same cycle is refused; spawn_ready reflects pre-edge state only.
REQ-030 Counters saturate at 16'hFFFF.

Reset
REQ-031 reset clears all valid bits, the y values, hit, miss, hit_count and miss_count to 0, and overrides tick, strum and spawn in the same cycle.
REQ-032 After reset, spawn_ready=1, in_note=0 and in_window=0.

Structure
REQ-033 A shared package holds the geometry constants, YW, and the slot record type (valid, y).
REQ-034 One sub-module, note_slot, holds one slot's state, its advance/clear logic, and its query and window compares; it is instantiated LANES*SLOTS times via generate.

Verification
REQ-035 Spawn lane 2 after reset, then 400 ticks -> y=350 and in_window[2]=1; expiry at tick 530 -> miss pulse, miss_count=1.
REQ-036 Note in window on lane 0, buttons=4'b0001, strum -> hit pulse next cycle, hit_count=1, slot freed, in_note[0]=0.
REQ-037 Fill all 3 slots of lane 1 -> spawn_ready=0 for lane 1; a fourth spawn_valid is not accepted; lane 3 spawn is still accepted.
REQ-038 Note in window on lane 0, buttons=4'b0011, strum -> hit and miss both pulse, hit_count=1, miss_count=1.
REQ-039 Strum and tick on the same cycle with a note at y=369 -> hit, no expiry, slot cleared.
REQ-040 Assert reset mid-scroll with 5 notes live -> all outputs 0 next cycle, spawn_ready=1.

Source files
------------

// File: rtl/note_lane_engine_pkg.sv
// Shared geometry defaults, slot record and counter helper for the note lane engine.
package note_lane_engine_pkg;

    localparam int PKG_YW       = 11;
    localparam int DEF_NOTE_H   = 50;
    localparam int DEF_HIT_Y    = 350;
    localparam int DEF_HIT_H    = 20;
    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_SPEED    = 1;

    typedef struct packed {
        logic                     valid;
        logic signed [PKG_YW-1:0] y;
    } slot_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum_s;
        sum_s = {1'b0, a} + {1'b0, b};
        if (sum_s[16]) begin
            return 16'hFFFF;
        end else begin
            return sum_s[15:0];
        end
    endfunction

endpackage

// File: rtl/note_lane_engine_slot.sv
// One note slot: position state, scroll/expiry, spawn/clear, and its scan-line and hit-bar compares.
module note_slot
    import note_lane_engine_pkg::*;
#(
    parameter int YW       = PKG_YW,
    parameter int NOTE_H   = DEF_NOTE_H,
    parameter int HIT_Y    = DEF_HIT_Y,
    parameter int HIT_H    = DEF_HIT_H,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int SPEED    = DEF_SPEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       spawn,
    input  logic       clear,
    input  logic [9:0] query_y,
    output logic       valid,
    output logic       in_note,
    output logic       in_window,
    output logic       expire
);

    localparam logic signed [YW-1:0] NOTE_H_Y  = YW'(NOTE_H);
    localparam logic signed [YW-1:0] HIT_Y_Y   = YW'(HIT_Y);
    localparam logic signed [YW-1:0] WIN_END_Y = YW'(HIT_Y + HIT_H);
    localparam logic signed [YW-1:0] SCREEN_Y  = YW'(SCREEN_H);
    localparam logic signed [YW-1:0] SPEED_Y   = YW'(SPEED);

    slot_t                slot_r;
    logic signed [YW-1:0] y_s;
    logic signed [YW-1:0] next_y_s;
    logic signed [YW-1:0] bottom_s;
    logic signed [YW-1:0] qy_s;
    logic                 off_screen_s;

    assign y_s          = YW'(slot_r.y);
    assign next_y_s     = y_s + SPEED_Y;
    assign bottom_s     = y_s + NOTE_H_Y;
    assign qy_s         = YW'($signed({1'b0, query_y}));
    assign off_screen_s = (next_y_s >= SCREEN_Y);

    assign valid     = slot_r.valid;
    assign in_note   = slot_r.valid & (qy_s >= y_s) & (qy_s < bottom_s);
    assign in_window = slot_r.valid & (y_s < WIN_END_Y) & (bottom_s > HIT_Y_Y);
    // A strum clear wins over the tick, so a struck note never counts as expired.
    assign expire    = tick & slot_r.valid & ~clear & off_screen_s;

    // Slot state: reset > strum clear > spawn > scroll.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_r <= '0;
        end else if (clear) begin
            slot_r.valid <= 1'b0;
        end else if (spawn) begin
            slot_r.valid <= 1'b1;
            slot_r.y     <= PKG_YW'(-NOTE_H_Y);
        end else if (tick && slot_r.valid) begin
            if (off_screen_s) begin
                slot_r.valid <= 1'b0;
            end else begin
                slot_r.y <= PKG_YW'(next_y_s);
            end
        end else begin
            slot_r <= slot_r;
        end
    end

endmodule

// File: rtl/note_lane_engine.sv
// Rhythm-game note lanes: spawn allocation, strum judging, hit/miss pulses and event counters.
module note_lane_engine
    import note_lane_engine_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int SLOTS    = 3,
    parameter int YW       = PKG_YW,
    parameter int NOTE_H   = DEF_NOTE_H,
    parameter int HIT_Y    = DEF_HIT_Y,
    parameter int HIT_H    = DEF_HIT_H,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int SPEED    = DEF_SPEED,
    localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             spawn_valid,
    input  logic [LW-1:0]    spawn_lane,
    output logic             spawn_ready,
    input  logic             strum,
    input  logic [LANES-1:0] buttons,
    input  logic [9:0]       query_y,
    output logic [LANES-1:0] in_note,
    output logic [LANES-1:0] in_window,
    output logic             hit,
    output logic             miss,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
);

    localparam int NS = LANES * SLOTS;

    logic [NS-1:0]    valid_s;
    logic [NS-1:0]    note_s;
    logic [NS-1:0]    win_s;
    logic [NS-1:0]    expire_s;
    logic [NS-1:0]    spawn_sel_s;
    logic [NS-1:0]    clear_s;
    logic [LANES-1:0] lane_free_s;
    logic [LANES-1:0] lane_window_s;
    logic [LANES-1:0] lane_hit_s;
    logic             strum_act_s;
    logic             strum_miss_s;
    logic             spawn_taken_s;
    logic             lane_found_s;
    logic [15:0]      hit_inc_s;
    logic [15:0]      miss_inc_s;
    logic             hit_r;
    logic             miss_r;
    logic [15:0]      hit_count_r;
    logic [15:0]      miss_count_r;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar s = 0; s < SLOTS; s++) begin : g_slot
            note_slot #(
                .YW(YW), .NOTE_H(NOTE_H), .HIT_Y(HIT_Y), .HIT_H(HIT_H),
                .SCREEN_H(SCREEN_H), .SPEED(SPEED)
            ) u_slot (
                .clk      (clk),
                .reset    (reset),
                .tick     (tick),
                .spawn    (spawn_sel_s[l*SLOTS+s]),
                .clear    (clear_s[l*SLOTS+s]),
                .query_y  (query_y),
                .valid    (valid_s[l*SLOTS+s]),
                .in_note  (note_s[l*SLOTS+s]),
                .in_window(win_s[l*SLOTS+s]),
                .expire   (expire_s[l*SLOTS+s])
            );
        end
        assign lane_free_s[l]   = ~&valid_s[l*SLOTS +: SLOTS];
        assign lane_window_s[l] = |win_s[l*SLOTS +: SLOTS];
        assign in_note[l]       = |note_s[l*SLOTS +: SLOTS];
    end

    assign in_window   = lane_window_s;
    assign spawn_ready = lane_free_s[spawn_lane];

    // A strum with nothing anywhere in the hit bar is treated as noise.
    assign strum_act_s  = strum & (|lane_window_s);
    assign lane_hit_s   = {LANES{strum_act_s}} & buttons & lane_window_s;
    assign strum_miss_s = strum_act_s &
                          ((|(buttons & ~lane_window_s)) | (buttons == {LANES{1'b0}}));

    // Spawn goes to the lowest free slot of the selected lane, judged on pre-edge occupancy.
    always_comb begin
        spawn_sel_s   = '0;
        spawn_taken_s = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (spawn_valid && spawn_ready && (LW'(l) == spawn_lane) &&
                    !spawn_taken_s && !valid_s[l*SLOTS+s]) begin
                    spawn_sel_s[l*SLOTS+s] = 1'b1;
                    spawn_taken_s          = 1'b1;
                end else begin
                    spawn_sel_s[l*SLOTS+s] = spawn_sel_s[l*SLOTS+s];
                end
            end
        end
    end

    // Each hit lane loses its lowest-index note inside the hit bar.
    always_comb begin
        clear_s      = '0;
        lane_found_s = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            lane_found_s = 1'b0;
            for (int s = 0; s < SLOTS; s++) begin
                if (lane_hit_s[l] && !lane_found_s && win_s[l*SLOTS+s]) begin
                    clear_s[l*SLOTS+s] = 1'b1;
                    lane_found_s       = 1'b1;
                end else begin
                    clear_s[l*SLOTS+s] = clear_s[l*SLOTS+s];
                end
            end
        end
    end

    // Per-cycle counter increments: one per struck note, one per expired slot plus one per missed strum.
    always_comb begin
        hit_inc_s  = 16'd0;
        miss_inc_s = {15'd0, strum_miss_s};
        for (int l = 0; l < LANES; l++) begin
            hit_inc_s = hit_inc_s + {15'd0, lane_hit_s[l]};
        end
        for (int i = 0; i < NS; i++) begin
            miss_inc_s = miss_inc_s + {15'd0, expire_s[i]};
        end
    end

    // Registered pulses and saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_r        <= 1'b0;
            miss_r       <= 1'b0;
            hit_count_r  <= 16'd0;
            miss_count_r <= 16'd0;
        end else begin
            hit_r        <= |lane_hit_s;
            miss_r       <= strum_miss_s | (|expire_s);
            hit_count_r  <= sat_add16(hit_count_r, hit_inc_s);
            miss_count_r <= sat_add16(miss_count_r, miss_inc_s);
        end
    end

    assign hit        = hit_r;
    assign miss       = miss_r;
    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;

endmodule

// File: tb/tb_note_lane_engine.sv
// Directed self-checking bench for note_lane_engine with hand-computed note positions.
module tb_note_lane_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        spawn_valid = 1'b0;
    logic [1:0]  spawn_lane = 2'd0;
    logic        spawn_ready;
    logic        strum = 1'b0;
    logic [3:0]  buttons = 4'd0;
    logic [9:0]  query_y = 10'd0;
    logic [3:0]  in_note;
    logic [3:0]  in_window;
    logic        hit;
    logic        miss;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;

    note_lane_engine dut (
        .clk(clk), .reset(reset), .tick(tick), .spawn_valid(spawn_valid),
        .spawn_lane(spawn_lane), .spawn_ready(spawn_ready), .strum(strum),
        .buttons(buttons), .query_y(query_y), .in_note(in_note), .in_window(in_window),
        .hit(hit), .miss(miss), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1; tick = 1'b0; spawn_valid = 1'b0; strum = 1'b0; buttons = 4'd0;
        step();
        reset = 1'b0;
    endtask

    task automatic spawn_on(input logic [1:0] lane);
        spawn_valid = 1'b1; spawn_lane = lane;
        step();
        spawn_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        spawn_lane = 2'd0; query_y = 10'd100; #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %0b exp 0", hit); end
        checks++; if (miss !== 1'b0) begin errors++; $display("FAIL reset_miss got %0b exp 0", miss); end
        checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", hit_count, miss_count); end
        checks++; if (spawn_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", spawn_ready); end
        checks++; if (in_note !== 4'b0000 || in_window !== 4'b0000) begin errors++; $display("FAIL reset_lanes got %b/%b exp 0000/0000", in_note, in_window); end
    endtask

    task automatic test_scroll_expire();
        apply_reset();
        spawn_on(2'd2);
        query_y = 10'd0; #1;
        checks++; if (in_note !== 4'b0000) begin errors++; $display("FAIL spawn_offscreen_note got %b exp 0000", in_note); end
        do_ticks(350);
        checks++; if (in_window !== 4'b0000) begin errors++; $display("FAIL window_y300 got %b exp 0000", in_window); end
        do_ticks(1);
        checks++; if (in_window !== 4'b0100) begin errors++; $display("FAIL window_y301 got %b exp 0100", in_window); end
        do_ticks(49);
        checks++; if (in_window !== 4'b0100) begin errors++; $display("FAIL window_y350 got %b exp 0100", in_window); end
        query_y = 10'd350; #1;
        checks++; if (in_note !== 4'b0100) begin errors++; $display("FAIL note_top got %b exp 0100", in_note); end
        query_y = 10'd399; #1;
        checks++; if (in_note !== 4'b0100) begin errors++; $display("FAIL note_bottom got %b exp 0100", in_note); end
        query_y = 10'd400; #1;
        checks++; if (in_note !== 4'b0000) begin errors++; $display("FAIL note_below got %b exp 0000", in_note); end
        query_y = 10'd349; #1;
        checks++; if (in_note !== 4'b0000) begin errors++; $display("FAIL note_above got %b exp 0000", in_note); end
        do_ticks(19);
        checks++; if (in_window !== 4'b0100) begin errors++; $display("FAIL window_y369 got %b exp 0100", in_window); end
        do_ticks(1);
        checks++; if (in_window !== 4'b0000) begin errors++; $display("FAIL window_y370 got %b exp 0000", in_window); end
        do_ticks(109);
        query_y = 10'd479; #1;
        checks++; if (miss !== 1'b0 || in_note !== 4'b0100) begin errors++; $display("FAIL pre_expiry got miss=%0b note=%b exp 0/0100", miss, in_note); end
        do_ticks(1);
        checks++; if (miss !== 1'b1) begin errors++; $display("FAIL expiry_miss got %0b exp 1", miss); end
        checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL expiry_count got %0d exp 1", miss_count); end
        checks++; if (in_note !== 4'b0000) begin errors++; $display("FAIL expiry_cleared got %b exp 0000", in_note); end
        step();
        checks++; if (miss !== 1'b0) begin errors++; $display("FAIL miss_one_cycle got %0b exp 0", miss); end
    endtask

    task automatic test_hit();
        apply_reset();
        spawn_on(2'd0);
        do_ticks(400);
        buttons = 4'b0001; strum = 1'b1;
        step();
        strum = 1'b0; buttons = 4'b0000; query_y = 10'd360; #1;
        checks++; if (hit !== 1'b1 || miss !== 1'b0) begin errors++; $display("FAIL hit_pulse got hit=%0b miss=%0b exp 1/0", hit, miss); end
        checks++; if (hit_count !== 16'd1 || miss_count !== 16'd0) begin errors++; $display("FAIL hit_counts got %0d/%0d exp 1/0", hit_count, miss_count); end
        checks++; if (in_note !== 4'b0000 || in_window !== 4'b0000) begin errors++; $display("FAIL hit_freed got %b/%b exp 0000/0000", in_note, in_window); end
        step();
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_one_cycle got %0b exp 0", hit); end
    endtask

    task automatic test_full_lane();
        apply_reset();
        spawn_on(2'd1);
        do_ticks(100);
        spawn_on(2'd1);
        do_ticks(100);
        spawn_on(2'd1);
        spawn_lane = 2'd1; query_y = 10'd160; #1;
        checks++; if (spawn_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", spawn_ready); end
        checks++; if (in_note !== 4'b0010) begin errors++; $display("FAIL full_note got %b exp 0010", in_note); end
        spawn_on(2'd1);
        spawn_lane = 2'd3; #1;
        checks++; if (spawn_ready !== 1'b1) begin errors++; $display("FAIL other_lane_ready got %0b exp 1", spawn_ready); end
        spawn_on(2'd3);
        do_ticks(330);
        spawn_lane = 2'd1; #1;
        checks++; if (miss_count !== 16'd1 || spawn_ready !== 1'b1) begin errors++; $display("FAIL first_expiry got cnt=%0d ready=%0b exp 1/1", miss_count, spawn_ready); end
        do_ticks(100);
        checks++; if (miss_count !== 16'd2) begin errors++; $display("FAIL second_expiry got %0d exp 2", miss_count); end
        do_ticks(99);
        checks++; if (miss_count !== 16'd2) begin errors++; $display("FAIL before_pair got %0d exp 2", miss_count); end
        do_ticks(1);
        checks++; if (miss_count !== 16'd4 || miss !== 1'b1) begin errors++; $display("FAIL pair_expiry got cnt=%0d miss=%0b exp 4/1", miss_count, miss); end
    endtask

    task automatic test_partial_miss();
        apply_reset();
        spawn_on(2'd0);
        do_ticks(400);
        buttons = 4'b0011; strum = 1'b1;
        step();
        strum = 1'b0; buttons = 4'b0000;
        checks++; if (hit !== 1'b1 || miss !== 1'b1) begin errors++; $display("FAIL partial_pulses got hit=%0b miss=%0b exp 1/1", hit, miss); end
        checks++; if (hit_count !== 16'd1 || miss_count !== 16'd1) begin errors++; $display("FAIL partial_counts got %0d/%0d exp 1/1", hit_count, miss_count); end
    endtask

    task automatic test_strum_tick();
        apply_reset();
        spawn_on(2'd0);
        do_ticks(419);
        buttons = 4'b0001; strum = 1'b1; tick = 1'b1;
        step();
        strum = 1'b0; tick = 1'b0; buttons = 4'b0000;
        checks++; if (hit !== 1'b1 || miss !== 1'b0) begin errors++; $display("FAIL strum_tick_pulses got hit=%0b miss=%0b exp 1/0", hit, miss); end
        checks++; if (hit_count !== 16'd1 || in_window !== 4'b0000) begin errors++; $display("FAIL strum_tick_clear got cnt=%0d win=%b exp 1/0000", hit_count, in_window); end
        do_ticks(200);
        checks++; if (miss_count !== 16'd0) begin errors++; $display("FAIL strum_tick_noexpire got %0d exp 0", miss_count); end
    endtask

    task automatic test_spawn_tick();
        apply_reset();
        tick = 1'b1;
        spawn_on(2'd0);
        do_ticks(350);
        checks++; if (in_window !== 4'b0000) begin errors++; $display("FAIL spawn_tick_y300 got %b exp 0000", in_window); end
        do_ticks(1);
        checks++; if (in_window !== 4'b0001) begin errors++; $display("FAIL spawn_tick_y301 got %b exp 0001", in_window); end
    endtask

    task automatic test_ignored_strum();
        apply_reset();
        buttons = 4'b0001; strum = 1'b1;
        step();
        strum = 1'b0; buttons = 4'b0000;
        checks++; if (hit !== 1'b0 || miss !== 1'b0 || miss_count !== 16'd0) begin errors++; $display("FAIL empty_strum got hit=%0b miss=%0b cnt=%0d exp 0/0/0", hit, miss, miss_count); end
        spawn_on(2'd0);
        do_ticks(400);
        buttons = 4'b0000; strum = 1'b1;
        step();
        strum = 1'b0;
        checks++; if (hit !== 1'b0 || miss !== 1'b1) begin errors++; $display("FAIL nobutton_pulses got hit=%0b miss=%0b exp 0/1", hit, miss); end
        checks++; if (miss_count !== 16'd1 || hit_count !== 16'd0 || in_window !== 4'b0001) begin errors++; $display("FAIL nobutton_state got %0d/%0d win=%b exp 1/0/0001", miss_count, hit_count, in_window); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        spawn_on(2'd0);
        spawn_on(2'd1);
        spawn_on(2'd2);
        spawn_on(2'd3);
        spawn_on(2'd0);
        do_ticks(400);
        checks++; if (in_window !== 4'b1111) begin errors++; $display("FAIL five_live got %b exp 1111", in_window); end
        buttons = 4'b1111; strum = 1'b1;
        step();
        checks++; if (hit !== 1'b1 || hit_count !== 16'd4 || in_window !== 4'b0001) begin errors++; $display("FAIL four_hits got hit=%0b cnt=%0d win=%b exp 1/4/0001", hit, hit_count, in_window); end
        reset = 1'b1; tick = 1'b1; spawn_valid = 1'b1; spawn_lane = 2'd2;
        step();
        reset = 1'b0; tick = 1'b0; spawn_valid = 1'b0; strum = 1'b0; buttons = 4'b0000;
        query_y = 10'd360; #1;
        checks++; if (hit !== 1'b0 || miss !== 1'b0 || hit_count !== 16'd0 || miss_count !== 16'd0) begin errors++; $display("FAIL midreset_regs got %0b %0b %0d %0d exp 0 0 0 0", hit, miss, hit_count, miss_count); end
        checks++; if (in_note !== 4'b0000 || in_window !== 4'b0000 || spawn_ready !== 1'b1) begin errors++; $display("FAIL midreset_lanes got %b %b %0b exp 0000 0000 1", in_note, in_window, spawn_ready); end
        query_y = 10'd0; #1;
        checks++; if (in_note !== 4'b0000) begin errors++; $display("FAIL midreset_nospawn got %b exp 0000", in_note); end
    endtask

    initial begin
        test_reset();
        test_scroll_expire();
        test_hit();
        test_full_lane();
        test_partial_miss();
        test_strum_tick();
        test_spawn_tick();
        test_ignored_strum();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
